// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl : instruction issue / writeback controller for the registered ALU.
//
// Accepts 16-bit instruction words over a valid/ready handshake, reads the
// operands from an internal register file, presents opcode and operands to
// the ALU for one cycle, then writes the ALU's registered result (or the LI
// immediate) back to the destination register. One instruction retires every
// three cycles; the next accept may coincide with the done pulse.
//
// Instruction format:
//   [15:12] op   (0..7 ALU ops, 8 = LI, 9..15 illegal)
//   [11:9]  rd   [8:6] rs   [5:3] rt   [8:0] imm9 (LI only, zero-extended)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   in_valid  in   instruction word valid
//   in_ready  out  controller can accept an instruction (registered)
//   in_instr  in   instruction word, sampled only at the accept edge
//   alu_op    out  opcode to ALU, 4'hF = no-op/hold (registered)
//   alu_a     out  ALU operand A (registered)
//   alu_b     out  ALU operand B (registered)
//   alu_out   in   registered ALU result, valid during the WB cycle
//   done      out  one-cycle pulse, instruction retired (registered)
//   err       out  illegal opcode seen (registered)
//   dbg_addr  in   register-file debug read address
//   dbg_data  out  combinational read of rf[dbg_addr], 0 for r0
//
// Build option:
//   ALU_CTRL_ILLEGAL_TRAP_EN - when defined, an illegal opcode sets err sticky,
//   suppresses its done pulse and parks the controller (in_ready = 0) until
//   rst. When undefined, an illegal opcode is a 3-cycle NOP with a one-cycle
//   err pulse coincident with done.
// -----------------------------------------------------------------------------
module alu_ctrl #(
    parameter int N    = 16,
    parameter int REGS = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [15:0]  in_instr,
    output logic [3:0]   alu_op,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    input  logic [N-1:0] alu_out,
    output logic         done,
    output logic         err,
    input  logic [2:0]   dbg_addr,
    output logic [N-1:0] dbg_data
);

    // Register index width; indices wrap modulo REGS by dropping upper bits.
    localparam int AW = (REGS > 1) ? $clog2(REGS) : 1;

    localparam logic [3:0] OP_LI  = 4'h8;
    localparam logic [3:0] OP_NOP = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } state_t;

    state_t         state;
    logic [N-1:0]   rf [REGS];
    logic [3:0]     op_q;
    logic [AW-1:0]  rd_q;
    logic [N-1:0]   imm_q;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic           trapped;
`endif

    // Decoded fields of the incoming word (only used at the accept edge).
    logic [3:0]     in_op;
    logic [AW-1:0]  in_rd;
    logic [AW-1:0]  in_rs;
    logic [AW-1:0]  in_rt;
    logic           in_is_alu;
    logic [N-1:0]   rs_val;
    logic [N-1:0]   rt_val;
    logic [N-1:0]   imm_ext;
    logic [AW-1:0]  dbg_idx;

    // Instruction field extraction and operand / debug reads of the register file.
    always_comb begin
        in_op     = in_instr[15:12];
        in_rd     = in_instr[9 +: AW];
        in_rs     = in_instr[6 +: AW];
        in_rt     = in_instr[3 +: AW];
        in_is_alu = (in_op[3] == 1'b0);
        imm_ext   = N'(in_instr[8:0]);
        dbg_idx   = dbg_addr[AW-1:0];
        // r0 is never written, but force zero explicitly so reads never depend on it.
        if (in_rs == '0) begin
            rs_val = '0;
        end else begin
            rs_val = rf[in_rs];
        end
        if (in_rt == '0) begin
            rt_val = '0;
        end else begin
            rt_val = rf[in_rt];
        end
        if (dbg_idx == '0) begin
            dbg_data = '0;
        end else begin
            dbg_data = rf[dbg_idx];
        end
    end

    // Controller FSM: accept / issue / writeback with registered outputs and register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            alu_op   <= OP_NOP;
            alu_a    <= '0;
            alu_b    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            op_q     <= 4'h0;
            rd_q     <= '0;
            imm_q    <= '0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            trapped  <= 1'b0;
`endif
            for (int i = 0; i < REGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            done <= 1'b0;
`ifndef ALU_CTRL_ILLEGAL_TRAP_EN
            err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_q     <= in_op;
                        rd_q     <= in_rd;
                        imm_q    <= imm_ext;
                        in_ready <= 1'b0;
                        state    <= ISSUE;
                        if (in_is_alu) begin
                            alu_op <= in_op;
                            alu_a  <= rs_val;
                            alu_b  <= rt_val;
                        end else begin
                            // LI and illegal ops never drive the ALU.
                            alu_op <= OP_NOP;
                        end
                    end else begin
                        // Also raises in_ready on the first edge after reset release.
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                        in_ready <= ~trapped;
`else
                        in_ready <= 1'b1;
`endif
                    end
                end
                ISSUE: begin
                    // The ALU captures op/operands at this edge; return it to hold.
                    alu_op <= OP_NOP;
                    state  <= WB;
                end
                WB: begin
                    state <= IDLE;
                    if (op_q[3] == 1'b0) begin
                        if (rd_q != '0) begin
                            rf[rd_q] <= alu_out;
                        end
                        done     <= 1'b1;
                        in_ready <= 1'b1;
                    end else if (op_q == OP_LI) begin
                        if (rd_q != '0) begin
                            rf[rd_q] <= imm_q;
                        end
                        done     <= 1'b1;
                        in_ready <= 1'b1;
                    end else begin
                        err <= 1'b1;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                        trapped  <= 1'b1;
                        in_ready <= 1'b0;
`else
                        done     <= 1'b1;
                        in_ready <= 1'b1;
`endif
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    alu_op   <= OP_NOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl : self-checking bench for alu_ctrl.
// The bench plays the role of the registered ALU, keeps an instruction-level
// model of the register file and handshake timing, compares every DUT output
// against that model on each falling edge, and pins the model with literal
// register values for directed instruction sequences.
// -----------------------------------------------------------------------------
module tb_alu_ctrl;

    localparam int N    = 16;
    localparam int REGS = 8;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_instr = 16'h0000;
    logic [3:0]    alu_op;
    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [N-1:0]  alu_out = '0;
    logic          done;
    logic          err;
    logic [2:0]    dbg_addr = 3'd0;
    logic [N-1:0]  dbg_data;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int err_cnt = 0;
    int err_done_cnt = 0;
    int acc [4];
    logic [15:0] list [4];

    alu_ctrl #(.N(N), .REGS(REGS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .done(done), .err(err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [N-1:0] alu_f(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a ^ b;
            4'd2: return a | b;
            4'd3: return a & b;
            4'd4: return (a == b) ? 16'd1 : 16'd0;
            4'd5: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            4'd6: return a << b[3:0];
            4'd7: return a >> b[3:0];
            default: return a;
        endcase
    endfunction

    // The ALU: registers a result whenever the opcode is not the hold code.
    always @(posedge clk) begin
        if (alu_op != 4'hF) alu_out <= alu_f(alu_op, alu_a, alu_b);
    end

    // ---------------- instruction-level model ----------------
    logic [N-1:0] m_rf [8];
    int           m_cnt;
    logic         m_ready, m_done, m_err, m_trapped;
    logic [3:0]   m_op;
    logic [N-1:0] m_a, m_b;
    logic [15:0]  m_instr;

    function automatic logic [N-1:0] rd_reg(input int idx);
        int i = idx % REGS;
        return (i == 0) ? '0 : m_rf[i];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0; m_ready <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
            m_trapped <= 1'b0; m_op <= 4'hF; m_a <= '0; m_b <= '0; m_instr <= 16'h0;
            for (int i = 0; i < 8; i++) m_rf[i] <= '0;
        end else begin
            m_done <= 1'b0;
            if (!m_trapped) m_err <= 1'b0;
            if (m_cnt == 0) begin
                if (m_ready && in_valid) begin
                    m_instr <= in_instr;
                    m_cnt   <= 1;
                    m_ready <= 1'b0;
                    if (in_instr[15:12] < 4'd8) begin
                        m_op <= in_instr[15:12];
                        m_a  <= rd_reg(int'(in_instr[8:6]));
                        m_b  <= rd_reg(int'(in_instr[5:3]));
                    end
                end else if (!m_trapped) begin
                    m_ready <= 1'b1;
                end
            end else if (m_cnt == 1) begin
                m_cnt <= 2;
                m_op  <= 4'hF;
            end else begin
                m_cnt <= 0;
                if (m_instr[15:12] < 4'd8 || m_instr[15:12] == 4'd8) begin
                    if ((int'(m_instr[11:9]) % REGS) != 0)
                        m_rf[int'(m_instr[11:9]) % REGS] <= (m_instr[15:12] == 4'd8) ?
                            N'(m_instr[8:0]) :
                            alu_f(m_instr[15:12], rd_reg(int'(m_instr[8:6])), rd_reg(int'(m_instr[5:3])));
                    m_done <= 1'b1; m_ready <= 1'b1;
                end else begin
                    m_err <= 1'b1;
                    if (TRAP) m_trapped <= 1'b1;
                    else begin m_done <= 1'b1; m_ready <= 1'b1; end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        check("in_ready", 32'(in_ready), 32'(m_ready));
        check("alu_op", 32'(alu_op), 32'(m_op));
        check("done", 32'(done), 32'(m_done));
        check("err", 32'(err), 32'(m_err));
        check("dbg_data", 32'(dbg_data), 32'(rd_reg(int'(dbg_addr))));
        if (m_cnt == 1 && m_op != 4'hF) begin
            check("alu_a", 32'(alu_a), 32'(m_a));
            check("alu_b", 32'(alu_b), 32'(m_b));
        end
        if (err) err_cnt++;
        if (err && done) err_done_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, rt, 3'b000};
    endfunction

    function automatic logic [15:0] li(input logic [2:0] rd, input logic [8:0] imm);
        return {4'h8, rd, imm};
    endfunction

    task automatic nb();
        @(negedge clk); #1;
    endtask

    task automatic send(input logic [15:0] ins);
        int n = 0;
        nb();
        while (!m_ready && n < 20) begin nb(); n++; end
        if (!m_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: got ready=0 expected ready=1 for instr %h", ins);
        end else begin
            in_valid = 1'b1; in_instr = ins;
            @(posedge clk); #1;
            in_valid = 1'b0; in_instr = 16'($urandom);
        end
    endtask

    task automatic idle();
        repeat (4) nb();
    endtask

    task automatic check_reg(input logic [2:0] a, input logic [N-1:0] exp);
        nb();
        dbg_addr = a;
        #1;
        check($sformatf("reg_r%0d", a), 32'(dbg_data), 32'(exp));
    endtask

    task automatic do_reset();
        nb(); rst = 1'b1;
        nb(); nb(); rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(in_ready), 32'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        nb(); nb();
        check("rst_ready", 32'(in_ready), 32'(1'b0));
        check("rst_alu_op", 32'(alu_op), 32'(4'hF));
        check("rst_done", 32'(done), 32'(1'b0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(in_ready), 32'(1'b1));

        // LI / LI / ADD
        send(li(3'd1, 9'h005)); send(li(3'd2, 9'h003)); send(enc(4'd0, 3'd3, 3'd1, 3'd2));
        idle();
        check_reg(3'd3, 16'h0008);

        // LI 0x1FF, SLT, SEQ, XOR, then shifts
        send(li(3'd1, 9'h1FF));
        send(enc(4'd5, 3'd4, 3'd2, 3'd1));
        send(enc(4'd4, 3'd5, 3'd1, 3'd1));
        send(enc(4'd1, 3'd6, 3'd1, 3'd1));
        idle();
        check_reg(3'd1, 16'h01FF);
        check_reg(3'd4, 16'h0001);
        check_reg(3'd5, 16'h0001);
        check_reg(3'd6, 16'h0000);
        send(enc(4'd6, 3'd6, 3'd1, 3'd2));
        send(enc(4'd7, 3'd5, 3'd1, 3'd2));
        idle();
        check_reg(3'd6, 16'h0FF8);
        check_reg(3'd5, 16'h003F);

        // r0 writes discarded
        send(li(3'd0, 9'h0AA)); send(enc(4'd0, 3'd7, 3'd0, 3'd0));
        idle();
        check_reg(3'd7, 16'h0000);
        check_reg(3'd0, 16'h0000);

        // Streaming with in_valid held high; junk targets r3 while not ready
        list[0] = li(3'd5, 9'h010); list[1] = li(3'd6, 9'h020);
        list[2] = enc(4'd2, 3'd7, 3'd5, 3'd6); list[3] = enc(4'd3, 3'd1, 3'd7, 3'd5);
        begin
            int idx = 0;
            int n = 0;
            in_valid = 1'b1;
            while (idx < 4 && n < 40) begin
                nb();
                if (m_ready) begin in_instr = list[idx]; acc[idx] = cyc; idx++; end
                else in_instr = {4'h8, 3'd3, 9'($urandom)};
                n++;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (idx < 4) begin
                tests++; fails++;
                $display("FAIL stream_timeout: got %0d accepts expected 4", idx);
            end
        end
        idle();
        for (int i = 0; i < 3; i++) check("accept_spacing", 32'(acc[i+1] - acc[i]), 32'd3);
        check_reg(3'd7, 16'h0030);
        check_reg(3'd1, 16'h0010);
        check_reg(3'd3, 16'h0008);

        // Illegal opcode 4'hC targeting r2
        err_cnt = 0; err_done_cnt = 0;
        send({4'hC, 3'd2, 9'h000});
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        repeat (6) nb();
        check("trap_err", 32'(err), 32'(1'b1));
        check("trap_ready", 32'(in_ready), 32'(1'b0));
        check("trap_err_with_done", 32'(err_done_cnt), 32'd0);
        check_reg(3'd2, 16'h0003);
`else
        idle();
        check("err_pulses", 32'(err_cnt), 32'd1);
        check("err_with_done", 32'(err_done_cnt), 32'd1);
        check_reg(3'd2, 16'h0003);
        send(li(3'd2, 9'h044));
        idle();
        check_reg(3'd2, 16'h0044);
        check("err_pulses_after", 32'(err_cnt), 32'd1);
`endif

        // Reset during ISSUE of ADD r3,r1,r2
        do_reset();
        send(li(3'd1, 9'h005)); send(li(3'd2, 9'h003)); send(enc(4'd0, 3'd3, 3'd1, 3'd2));
        #2; rst = 1'b1; #1;
        check("arst_ready", 32'(in_ready), 32'(1'b0));
        check("arst_alu_op", 32'(alu_op), 32'(4'hF));
        check("arst_alu_a", 32'(alu_a), 32'd0);
        check("arst_alu_b", 32'(alu_b), 32'd0);
        check("arst_done", 32'(done), 32'(1'b0));
        check("arst_err", 32'(err), 32'(1'b0));
        nb(); nb(); rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_arst", 32'(in_ready), 32'(1'b1));
        idle();
        check_reg(3'd3, 16'h0000);
        check_reg(3'd1, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
- Instruction issue/writeback controller on the driving side of the registered ALU.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes them.
- Reads operands from an internal register file, drives the ALU's opcode and operand inputs, then writes the registered ALU result back to the destination register.
- Sits between the fetch logic and the ALU in the smallCPU datapath.

Parameters:
N, 16, datapath width; must equal the ALU's N.
REGS, 8, number of registers (power of two, ≤8); r0 reads as zero.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  instruction word valid
in_ready  output  1  controller can accept an instruction
in_instr  input  16  instruction: [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [8:0] imm9 (LI only)
alu_op  output  4  opcode to ALU
alu_a  output  N  ALU operand A
alu_b  output  N  ALU operand B
alu_out  input  N  registered ALU result
done  output  1  one-cycle pulse: instruction retired
err  output  1  illegal opcode seen
dbg_addr  input  3  register-file debug read address
dbg_data  output  N  combinational read of rf[dbg_addr]; 0 when dbg_addr = 0

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; all registers are cleared to 0.
  - in_ready=0 while rst is high, then 1 from the first cycle after deassertion.
  - alu_op=4'hF, which the ALU treats as no-op/hold.
  - alu_a=alu_b=0, done=0, err=0.
  - Reset mid-instruction aborts it with no writeback.
- Opcode decode:
  - 0–7 are ALU ops: ADD, XOR, OR, AND, SEQ, SLT, SL, SR.
  - 8 is LI: rd <= zero-extended imm9.
  - 9–15 are illegal.
- FSM states are IDLE, ISSUE, WB.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at edge E0, latch op/rd.
  - For ALU ops, register alu_op=op, alu_a=rf[rs], alu_b=rf[rt]. For LI, latch imm.
  - Go to ISSUE.
  - An illegal op at E0 goes to ISSUE with alu_op held at 4'hF.
- ISSUE:
  - in_ready=0; alu_op/alu_a/alu_b are stable for the whole cycle.
  - The ALU registers its result at edge E1; at E1, alu_op returns to 4'hF.
  - Go to WB.
- WB:
  - in_ready=0; alu_out is valid this cycle.
  - At E2: ALU op writes rf[rd] <= alu_out; LI writes rf[rd] <= imm; illegal writes nothing.
  - done is registered high for the cycle after E2.
  - Go to IDLE.
- Latency and throughput:
  - 3 cycles from accept to done.
  - Back-to-back instructions: one accepted every 3 cycles. The next accept can coincide with the done cycle.
- Register-file rules:
  - Writes to r0 are discarded.
  - When REGS<8, register indices wrap modulo REGS.
  - An instruction reading the register written by the previous instruction sees the new value; no hazard exists, because writeback completes before the next accept.
- Width: alu_a/alu_b are full N bits. SEQ/SLT results arrive from the ALU already zero-extended and are written unchanged.
- in_instr is sampled only at the accept edge. Changes while in_ready=0 are ignored.
- err:
  - Registered high at E2 for an illegal op.
  - Default build: one-cycle pulse, coincident with done.

Optional Feature:
ALU_CTRL_ILLEGAL_TRAP_EN
- Defined:
  - An illegal opcode sets err sticky.
  - in_ready stays 0 and the FSM parks in IDLE until rst.
  - No done pulse for the trapping instruction.
- Undefined: an illegal opcode behaves as a 3-cycle NOP with done and a one-cycle err pulse, and processing continues.

Test Plan:
- LI r1,0x005 then LI r2,0x003 then ADD r3,r1,r2 -> dbg r3=0x0008; done pulses exactly 3 cycles after each accept; alu_op=0 only in the ADD's ISSUE cycle, otherwise 4'hF.
- LI r1,0x1FF; SLT r4,r2,r1 (r2=3) -> r4=0x0001; SEQ r5,r1,r1 -> r5=0x0001; XOR r6,r1,r1 -> r6=0x0000.
- LI r0,0x0AA then ADD r7,r0,r0 -> r7=0x0000 and dbg_data(0)=0.
- in_valid held high with 4 instructions -> accepts exactly every 3rd cycle; in_instr changes while in_ready=0 have no effect.
- Opcode 4'hC -> no register changes. Without the macro: err and done pulse together, and the next instruction executes normally. With ALU_CTRL_ILLEGAL_TRAP_EN: err stays 1 and in_ready stays 0 until rst.
- Assert rst during ISSUE of ADD r3,r1,r2 -> r3 stays 0, done never pulses, all outputs are at reset values immediately (async); after release in_ready=1 the next cycle.
